// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shift/rotate unit.
//   - OP_* : 3-bit operation encoding presented on the op port
//   - state_t : controller states (IDLE / SHIFT / DONE)
//   - is_left(): true for ops whose bits move towards the MSB
package shifter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SHL = 3'd0;
  localparam logic [OP_W-1:0] OP_SHR = 3'd1;
  localparam logic [OP_W-1:0] OP_SAL = 3'd2;
  localparam logic [OP_W-1:0] OP_SAR = 3'd3;
  localparam logic [OP_W-1:0] OP_ROL = 3'd4;
  localparam logic [OP_W-1:0] OP_ROR = 3'd5;
  localparam logic [OP_W-1:0] OP_RCL = 3'd6;
  localparam logic [OP_W-1:0] OP_RCR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_left(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SAL) || (op == OP_ROL) || (op == OP_RCL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step, purely combinational.
// Ports:
//   op    : operation (OP_* encoding)
//   r, c  : current working operand and carry
//   r_nxt : operand after one step
//   c_nxt : carry after one step
// RCL/RCR treat {C,R} as a single (WIDTH+1)-bit ring.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] r,
  input  logic             c,
  output logic [WIDTH-1:0] r_nxt,
  output logic             c_nxt
);

  // NOTE: every output gets a default before the case so no path can
  // leave it unassigned; that is what keeps this block free of latches.
  always_comb begin
    r_nxt = r;
    c_nxt = c;
    case (op)
      OP_SHL, OP_SAL: begin
        c_nxt = r[WIDTH-1];
        r_nxt = {r[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        c_nxt = r[0];
        r_nxt = {1'b0, r[WIDTH-1:1]};
      end
      OP_SAR: begin
        c_nxt = r[0];
        r_nxt = {r[WIDTH-1], r[WIDTH-1:1]};
      end
      OP_ROL: begin
        c_nxt = r[WIDTH-1];
        r_nxt = {r[WIDTH-2:0], r[WIDTH-1]};
      end
      OP_ROR: begin
        c_nxt = r[0];
        r_nxt = {r[0], r[WIDTH-1:1]};
      end
      OP_RCL: {c_nxt, r_nxt} = {r, c};
      OP_RCR: {r_nxt, c_nxt} = {c, r};
      default: ;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: one bit per clock, start/busy/done handshake.
// Ports:
//   clk, rst : clock (rising edge), synchronous active-high reset
//   start    : request, sampled only while idle
//   op       : OP_* operation select
//   din      : operand;  cnt : shift count (masked by CNT_MASK at accept)
//   cf_in    : carry in
//   busy     : high while not idle;  done : one-cycle completion pulse
//   dout, cf_out, of_out : result and flags, held until next completion/reset
// Optional build macro ITER_SHIFTER_OF_EN: computes the overflow flag;
// without it of_out is tied low.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter int CNT_MASK = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] cnt,
  input  logic             cf_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cf_out,
  output logic             of_out
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, step_r;
  logic             c_q, c_d, step_c;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] n_q, n_d, cnt_masked;
  logic             load_out;
`ifdef ITER_SHIFTER_OF_EN
  logic             of_d, of_q;
`endif

  assign cnt_masked = cnt & CNT_W'(CNT_MASK);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .r     (r_q),
    .c     (c_q),
    .r_nxt (step_r),
    .c_nxt (step_c)
  );

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and working-register update. load_out marks the transition
  // into DONE so the outputs can be captured from the final R/C values.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    op_d     = op_q;
    n_d      = n_q;
    load_out = 1'b0;
`ifdef ITER_SHIFTER_OF_EN
    of_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          r_d  = din;
          c_d  = cf_in;
          op_d = op;
          n_d  = cnt_masked;
          if (cnt_masked == '0) begin
            // Zero count: pass operand and carry straight through, OF stays 0.
            state_d  = ST_DONE;
            load_out = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        r_d = step_r;
        c_d = step_c;
        n_d = n_q - 1'b1;
        if (n_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          load_out = 1'b1;
`ifdef ITER_SHIFTER_OF_EN
          of_d = is_left(op_q) ? (step_r[WIDTH-1] ^ step_c)
                               : (step_r[WIDTH-1] ^ step_r[WIDTH-2]);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      c_q    <= 1'b0;
      op_q   <= OP_SHL;
      n_q    <= '0;
      dout   <= '0;
      cf_out <= 1'b0;
    end else begin
      r_q  <= r_d;
      c_q  <= c_d;
      op_q <= op_d;
      n_q  <= n_d;
      if (load_out) begin
        dout   <= r_d;
        cf_out <= c_d;
      end
    end
  end

`ifdef ITER_SHIFTER_OF_EN
  always_ff @(posedge clk) begin
    if (rst)           of_q <= 1'b0;
    else if (load_out) of_q <= of_d;
  end
  assign of_out = of_q;
`else
  assign of_out = 1'b0;
`endif

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (WIDTH=16, CNT_W=8, CNT_MASK=31).
// Expected results come from an arithmetic reference model of the
// shift/rotate rules (whole-count shifts and ring rotations).
module tb_iter_shifter;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] din;
  logic [7:0]  cnt;
  logic        cf_in;
  logic        busy, done, cf_out, of_out;
  logic [15:0] dout;

  int tests = 0;
  int fails = 0;

  iter_shifter #(.WIDTH(16), .CNT_W(8), .CNT_MASK(31)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .din    (din),
    .cnt    (cnt),
    .cf_in  (cf_in),
    .busy   (busy),
    .done   (done),
    .dout   (dout),
    .cf_out (cf_out),
    .of_out (of_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int k, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    if (k == 0) return v & m;
    return ((v << k) | (v >> (w - k))) & m;
  endfunction

  // Returns {of, c, r[15:0]} for the whole operation.
  function automatic logic [17:0] model(input logic [2:0] o, input logic [15:0] d16,
                                        input logic [7:0] k, input logic cf);
    logic [63:0] d, r, v, m;
    logic        c, of, sgn;
    int          n;
    d = 64'(d16);
    m = (64'd1 << W) - 64'd1;
    n = int'(k & 8'd31);
    r = d;
    c = cf;
    if (n != 0) begin
      case (o)
        3'd0, 3'd2: begin
          r = (n >= W) ? 64'd0 : ((d << n) & m);
          c = (n <= W) ? d[W-n] : 1'b0;
        end
        3'd1: begin
          r = d >> n;
          c = (n <= W) ? d[n-1] : 1'b0;
        end
        3'd3: begin
          sgn = d[W-1];
          r = (n >= W) ? (sgn ? m : 64'd0)
                       : ((d >> n) | (sgn ? (m & ~(m >> n)) : 64'd0));
          c = (n <= W) ? d[n-1] : sgn;
        end
        3'd4: begin
          r = rotl(d, n % W, W);
          c = r[0];
        end
        3'd5: begin
          r = rotl(d, (W - (n % W)) % W, W);
          c = r[W-1];
        end
        3'd6: begin
          v = rotl((64'(cf) << W) | d, n % (W + 1), W + 1);
          r = v & m;
          c = v[W];
        end
        default: begin
          v = rotl((d << 1) | 64'(cf), (W + 1 - (n % (W + 1))) % (W + 1), W + 1);
          r = (v >> 1) & m;
          c = v[0];
        end
      endcase
    end
`ifdef ITER_SHIFTER_OF_EN
    if (n == 0)                                      of = 1'b0;
    else if (o == 3'd0 || o == 3'd2 || o == 3'd4 || o == 3'd6) of = r[W-1] ^ c;
    else                                             of = r[W-1] ^ r[W-2];
`else
    of = 1'b0;
`endif
    return {of, c, r[15:0]};
  endfunction

  // Issues one request (inputs driven on the falling edge), optionally pulses
  // a conflicting start while busy, then checks latency, results and hold.
  task automatic run_op(input logic [2:0] o, input logic [15:0] d, input logic [7:0] k,
                        input logic c, input bit inject, input string tag);
    logic [17:0] e;
    int          n;
    int          lat;
    e = model(o, d, k, c);
    n = int'(k & 8'd31);
    @(negedge clk);
    op = o; din = d; cnt = k; cf_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din   = 16'($urandom);
    op    = 3'($urandom);
    cnt   = 8'($urandom);
    cf_in = 1'($urandom);
    lat   = 0;
    if (inject && n >= 1) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      start = 1'b1; din = ~d; op = o ^ 3'd1; cnt = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
    end
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(n));
    check({tag, " dout"},    64'(dout),   64'(e[15:0]));
    check({tag, " cf_out"},  64'(cf_out), 64'(e[16]));
    check({tag, " of_out"},  64'(of_out), 64'(e[17]));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'({done, busy}), 64'd0);
    check({tag, " dout hold"},  64'(dout), 64'(e[15:0]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; din = '0; cnt = '0; cf_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 64'({busy, done, dout, cf_out, of_out}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'd0, 16'h8001, 8'd1,    1'b0, 1'b0, "shl 8001");
    run_op(3'd3, 16'h8000, 8'd3,    1'b0, 1'b0, "sar 8000");
    run_op(3'd5, 16'h0001, 8'd4,    1'b0, 1'b0, "ror 0001");
    run_op(3'd6, 16'h8000, 8'd1,    1'b0, 1'b0, "rcl n1");
    run_op(3'd6, 16'h8000, 8'd17,   1'b0, 1'b0, "rcl n17");
    run_op(3'd4, 16'h1234, 8'h20,   1'b1, 1'b0, "rol masked0");
    run_op(3'd7, 16'h0001, 8'd1,    1'b1, 1'b0, "rcr n1");
    run_op(3'd1, 16'hFFFF, 8'd31,   1'b1, 1'b0, "shr sat");
    run_op(3'd3, 16'h8421, 8'd20,   1'b0, 1'b0, "sar sat");
    run_op(3'd2, 16'h4000, 8'd16,   1'b0, 1'b0, "sal n16");
    run_op(3'd0, 16'hA5A5, 8'd5,    1'b0, 1'b1, "shl ignore");

    // Reset in the middle of a long operation.
    @(negedge clk);
    op = 3'd0; din = 16'hFFFF; cnt = 8'd10; cf_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid-op reset", 64'({busy, done, dout, cf_out, of_out}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 16'h00FF, 8'd10, 1'b0, 1'b0, "after reset");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), 16'($urandom), 8'($urandom_range(0, 40)), 1'($urandom),
             (i % 5) == 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Parametrised multi-cycle shift/rotate unit for the CPU datapath, successor to the fixed byte/word shifter. It takes an operand of WIDTH bits, an 8-way op select, a count and a carry-in, then shifts one bit per clock. It returns the result with carry and overflow flags through a start/busy/done handshake. It sits between the register file/flag register and the ALU result mux.

Parameters:
WIDTH, 16, operand width in bits; legal values 8..64.
CNT_W, 8, width of the cnt port.
CNT_MASK, 31, AND-mask applied to cnt at accept; gives the effective count n.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
op  in  3  0 SHL, 1 SHR, 2 SAL, 3 SAR, 4 ROL, 5 ROR, 6 RCL, 7 RCR
din  in  WIDTH  operand
cnt  in  CNT_W  shift count
cf_in  in  1  carry flag in
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle completion pulse
dout  out  WIDTH  result
cf_out  out  1  carry flag out
of_out  out  1  overflow flag out

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high; it wins over every other input, including mid-operation. On reset: state=IDLE, busy=0, done=0, dout=0, cf_out=0, of_out=0. The working registers are cleared.
- FSM states:
  - IDLE: on start=1, latch din into R, cf_in into C, op, and n = cnt & CNT_MASK. Go to DONE if n==0, otherwise go to SHIFT.
  - SHIFT: perform one step per cycle and decrement n. After the step with n==1, go to DONE.
  - DONE: done=1 for exactly this cycle. dout, cf_out and of_out are loaded from R/C/OF at entry. Return to IDLE next cycle.
- Latency: start accepted in cycle 0, done in cycle n+1. For n==0, done comes in cycle 1 with dout=din and cf_out=cf_in.
- start while busy (SHIFT or DONE) is ignored and not queued. din/cnt/op/cf_in may change freely after accept.
- dout, cf_out and of_out hold their value from DONE until the next DONE or reset.
- Per-step rules (W=WIDTH):
  - SHL/SAL: C=R[W-1]; R={R[W-2:0],0}.
  - SHR: C=R[0]; R={0,R[W-1:1]}.
  - SAR: C=R[0]; R={R[W-1],R[W-1:1]}.
  - ROL: C=R[W-1]; R={R[W-2:0],R[W-1]}.
  - ROR: C=R[0]; R={R[0],R[W-1:1]}.
  - RCL: {C,R}={R,C}, a (W+1)-bit ring.
  - RCR: {R,C}={C,R}, a (W+1)-bit ring.
- Counts larger than W are legal. Shifts saturate to 0 (or all sign bits for SAR). Rotates wrap around the ring.

Optional Feature:
ITER_SHIFTER_OF_EN defined:
- of_out is computed from the final R/C at DONE.
- Left ops (SHL/SAL/ROL/RCL): of_out = R[W-1]^C.
- Right ops (SHR/SAR/ROR/RCR): of_out = R[W-1]^R[W-2].
- For n==0, of_out=0.
ITER_SHIFTER_OF_EN undefined: of_out is tied to 0 and no OF logic is present.

Decomposition:
- Package shifter_pkg holds:
  - the op encoding localparams (OP_SHL..OP_RCR);
  - the FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE);
  - a helper predicate is_left(op).
- Sub-module shift_step: purely combinational one-bit step. Inputs op, R, C; outputs next R and next C. Instantiated once in iter_shifter.

Test Plan (WIDTH=16, CNT_MASK=31):
- SHL din=0x8001 cnt=1 cf_in=0 -> done in cycle 2, dout=0x0002, cf_out=1, of_out=1 (with OF_EN).
- SAR din=0x8000 cnt=3 -> done in cycle 4, dout=0xF000, cf_out=0, of_out=0. Then ROR din=0x0001 cnt=4 -> dout=0x1000, cf_out=0.
- RCL din=0x8000 cf_in=0 cnt=1 -> dout=0x0000, cf_out=1. RCL din=0x8000 cf_in=0 cnt=17 -> dout=0x8000, cf_out=0, done in cycle 18.
- cnt=0x20 (masked to 0) with ROL din=0x1234 cf_in=1 -> done in cycle 1, dout=0x1234, cf_out=1.
- start pulsed during SHIFT with different din -> ignored; result matches the first request. Back-to-back start in the cycle after done is accepted.
- rst asserted in the middle of SHL cnt=10 -> next cycle busy=0, done=0, dout=0, cf_out=0. A new request then completes correctly.
